risky_memarb: RTL and testbench
===============================

# risky_memarb

Parametrised single-port memory with an N-requester arbiter. It replaces the temporary dual-port memory inside `risky`. Fetch, load/store and any later masters share one synchronous RAM port through valid/ready handshakes. A requester that loses arbitration sees `req_ready` low, and that signal is its stall source into the pipeline's global stall logic.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 10: word-address width; depth is 2^ADDR_WIDTH words.
- `PORTS`, 2: number of requesters; range 1..8.
- `FIXED_PRIORITY`, 0:
  - 0 = round-robin arbitration.
  - 1 = static priority, port 0 highest.

Ports:
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input PORTS: per-port request present.
- `req_ready` output PORTS: per-port grant; combinational; at most one bit set.
- `req_write` input PORTS: 1 = write, 0 = read.
- `req_addr` input PORTS*ADDR_WIDTH: word address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` input PORTS*DATA_WIDTH: write data, packed the same way.
- `req_be` input PORTS*DATA_WIDTH/8: byte enables; bit 0 selects bits [7:0].
- `rsp_valid` output PORTS: one-cycle pulse when read data is available.
- `rsp_rdata` output PORTS*DATA_WIDTH: per-port read data.

## Operation
- Handshake: a transfer occurs on port i at a rising edge where `req_valid[i] && req_ready[i]`.
  - Requester holds valid, write, addr, wdata and be stable until accepted.
  - Valid must not be withdrawn before acceptance.
- Grant logic (combinational from `req_valid` and pointer):
  - Round-robin: search starts at port `(last+1) mod PORTS` and grants the first valid port.
  - Static priority: grant the lowest-index valid port.
  - No valid requests: `req_ready` = 0.
- Pointer `last`:
  - Updates to the granted index only on a transfer.
  - Unchanged on idle cycles.
  - Reset value is PORTS-1, so port 0 wins first.
- Write transfer:
  - Bytes with `be`=1 are written at that edge; other bytes keep their old value.
  - be=0 is a legal no-op write.
  - No response is generated.
- Read transfer:
  - Memory read at that edge.
  - `rsp_rdata[i]` is registered with the word and `rsp_valid[i]` pulses for exactly the next cycle.
  - `rsp_rdata[i]` holds that value until port i's next read response.
- Ordering: a read accepted the cycle after a write to the same address returns the new data. Read and write can never occur in the same cycle, because there is one physical port.
- Fairness: with round-robin, a continuously valid port is granted within PORTS cycles. With static priority, starvation of higher-index ports is permitted.
- Memory contents are not reset; reads of unwritten words return X in simulation.

## Timing
- Reset values:
  - `rsp_valid` = 0.
  - All `rsp_rdata` = 0.
  - `last` = PORTS-1.
  - `req_ready` follows the grant logic even while `rst_n` is low.
  - Transfers are ignored while `rst_n` is low: no memory write, no pointer update.
- Read latency: 1 cycle from accepting edge to `rsp_valid`.
- Throughput: one transfer per cycle across all ports.
- Back-to-back reads on one port produce consecutive `rsp_valid` pulses.
- Reset mid-operation: an asserted `rst_n` clears any pending or just-registered response immediately. No response is emitted after reset release for a pre-reset request.
- PORTS=1: `req_ready` equals `req_valid`; the pointer is constant.

## Test plan
- Reset: hold `rst_n`=0 with port 0 valid read to addr 5 → `rsp_valid`=0, `rsp_rdata`=0, no memory change. After release, first edge accepts; `rsp_valid[0]`=1 one cycle later.
- Write/read: port 1 writes addr 3 with 0xDEADBEEF, be=4'b1111. The next cycle port 1 reads addr 3 → `rsp_rdata[1]`=0xDEADBEEF with `rsp_valid[1]` one cycle after the read is accepted.
- Byte enables: over 0xDEADBEEF at addr 3, write 0x11223344 with be=4'b0101 → a subsequent read returns 0xDE22BE44.
- Contention, both ports continuously valid:
  - FIXED_PRIORITY=0 → grants alternate 0,1,0,1.
  - FIXED_PRIORITY=1 → port 0 granted every cycle; `req_ready[1]` stays 0.
- PORTS=3, all valid for 6 cycles → grant order 0,1,2,0,1,2. If port 1 drops valid after its first grant, the order continues 2,0,2,0.
- Reset mid-read: assert `rst_n`=0 in the cycle after a read is accepted → `rsp_valid` is never seen high. After release, port 0 is granted first.

Source files
------------

// File: rtl/risky_memarb.sv
// Single-port synchronous RAM shared by PORTS requesters through a round-robin or fixed-priority grant.
// Reads return one cycle after acceptance; a requester that loses arbitration sees req_ready low and must hold its request.
module risky_memarb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int PORTS          = 2,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PORTS-1:0]               req_valid,
  output logic [PORTS-1:0]               req_ready,
  input  logic [PORTS-1:0]               req_write,
  input  logic [PORTS*ADDR_WIDTH-1:0]    req_addr,
  input  logic [PORTS*DATA_WIDTH-1:0]    req_wdata,
  input  logic [PORTS*DATA_WIDTH/8-1:0]  req_be,
  output logic [PORTS-1:0]               rsp_valid,
  output logic [PORTS*DATA_WIDTH-1:0]    rsp_rdata
);
  localparam int BW    = DATA_WIDTH / 8;
  localparam int IW    = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [IW-1:0]         r_last;
  logic [PORTS-1:0]      r_rsp_vld;
  logic [DATA_WIDTH-1:0] r_rdata [PORTS];
  logic [DATA_WIDTH-1:0] r_mem   [DEPTH];

  int                    w_start;
  logic [2*PORTS-1:0]    w_dbl;
  logic [PORTS-1:0]      w_rot;
  logic                  w_any;
  logic [IW-1:0]         w_gidx;
  logic [PORTS-1:0]      w_grant;
  logic                  w_write;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BW-1:0]         w_be;

  // Rotate the valid vector so the search always begins at bit 0, then map back.
  always_comb begin
    w_start = (FIXED_PRIORITY != 0) ? 0 : (int'(r_last) + 1) % PORTS;
    w_dbl   = {req_valid, req_valid};
    w_rot   = PORTS'(w_dbl >> w_start);
    w_any   = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any  = 1'b1;
        w_gidx = IW'((w_start + k) % PORTS);
      end
    end
    w_grant = '0;
    if (w_any) w_grant[w_gidx] = 1'b1;
  end

  always_comb begin
    w_write = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_be    = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (w_grant[p]) begin
        w_write = req_write[p];
        w_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        w_be    = req_be[p*BW +: BW];
      end
    end
  end

  assign req_ready = w_grant;

  // RAM contents are never reset; the reset branch only blocks writes while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last    <= IW'(PORTS - 1);
      r_rsp_vld <= '0;
      for (int p = 0; p < PORTS; p++) r_rdata[p] <= '0;
    end else begin
      if (w_any) r_last <= w_gidx;
      if (w_any && w_write) begin
        for (int b = 0; b < BW; b++) begin
          if (w_be[b]) r_mem[w_addr][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        r_rsp_vld[p] <= w_grant[p] && !w_write;
        if (w_grant[p] && !w_write) r_rdata[p] <= r_mem[w_addr];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata[p];
  end

  assign rsp_valid = r_rsp_vld;

endmodule

// File: tb/tb_risky_memarb.sv
// Drives three arbiter configurations (2-port RR, 2-port fixed, 3-port RR) against a behavioural model.
module tb_risky_memarb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  a_vld, a_wr, a_rdy, a_rv;
  logic [19:0] a_addr;
  logic [63:0] a_wd, a_rd;
  logic [7:0]  a_be;
  logic [1:0]  b_vld, b_wr, b_rdy, b_rv;
  logic [19:0] b_addr;
  logic [63:0] b_wd, b_rd;
  logic [7:0]  b_be;
  logic [2:0]  c_vld, c_wr, c_rdy, c_rv;
  logic [29:0] c_addr;
  logic [95:0] c_wd, c_rd;
  logic [11:0] c_be;

  risky_memarb #(.PORTS(2), .FIXED_PRIORITY(0)) u_rr2 (
    .clk(clk), .rst_n(rst_n), .req_valid(a_vld), .req_ready(a_rdy), .req_write(a_wr),
    .req_addr(a_addr), .req_wdata(a_wd), .req_be(a_be), .rsp_valid(a_rv), .rsp_rdata(a_rd));
  risky_memarb #(.PORTS(2), .FIXED_PRIORITY(1)) u_fp2 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_vld), .req_ready(b_rdy), .req_write(b_wr),
    .req_addr(b_addr), .req_wdata(b_wd), .req_be(b_be), .rsp_valid(b_rv), .rsp_rdata(b_rd));
  risky_memarb #(.PORTS(3), .FIXED_PRIORITY(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .req_valid(c_vld), .req_ready(c_rdy), .req_write(c_wr),
    .req_addr(c_addr), .req_wdata(c_wd), .req_be(c_be), .rsp_valid(c_rv), .rsp_rdata(c_rd));

  // Requester-side state, [instance][port]
  logic        s_vld [3][3];
  logic        s_wr  [3][3];
  logic [9:0]  s_addr[3][3];
  logic [31:0] s_wd  [3][3];
  logic [3:0]  s_be  [3][3];
  logic        s_acc [3][3];

  // Reference model state
  int          m_last [3];
  logic        m_rv   [3][3];
  logic [31:0] m_rd   [3][3];
  logic        m_known[3][3];
  int          m_wait [3][3];
  logic [31:0] m_mem  [int];
  int          fill_cnt[3];
  int          dir_idx[3];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      a_vld[p] = s_vld[0][p]; a_wr[p] = s_wr[0][p]; a_addr[p*10 +: 10] = s_addr[0][p];
      a_wd[p*32 +: 32] = s_wd[0][p]; a_be[p*4 +: 4] = s_be[0][p];
      b_vld[p] = s_vld[1][p]; b_wr[p] = s_wr[1][p]; b_addr[p*10 +: 10] = s_addr[1][p];
      b_wd[p*32 +: 32] = s_wd[1][p]; b_be[p*4 +: 4] = s_be[1][p];
    end
    for (int p = 0; p < 3; p++) begin
      c_vld[p] = s_vld[2][p]; c_wr[p] = s_wr[2][p]; c_addr[p*10 +: 10] = s_addr[2][p];
      c_wd[p*32 +: 32] = s_wd[2][p]; c_be[p*4 +: 4] = s_be[2][p];
    end
  end

  function automatic int nports(int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic logic [2:0] get_rdy(int i);
    case (i)
      0:       return {1'b0, a_rdy};
      1:       return {1'b0, b_rdy};
      default: return c_rdy;
    endcase
  endfunction

  function automatic logic [2:0] get_rv(int i);
    case (i)
      0:       return {1'b0, a_rv};
      1:       return {1'b0, b_rv};
      default: return c_rv;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(int i, int p);
    case (i)
      0:       return a_rd[p*32 +: 32];
      1:       return b_rd[p*32 +: 32];
      default: return c_rd[p*32 +: 32];
    endcase
  endfunction

  // Round-robin: first valid port scanning from last+1; fixed: lowest valid index.
  function automatic int exp_grant(int i);
    int np = nports(i);
    for (int k = 0; k < np; k++) begin
      int c = (i == 1) ? k : (m_last[i] + 1 + k) % np;
      if (s_vld[i][c]) return c;
    end
    return -1;
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_last[i] = nports(i) - 1;
      for (int p = 0; p < 3; p++) begin
        m_rv[i][p] = 1'b0; m_rd[i][p] = '0; m_known[i][p] = 1'b1; m_wait[i][p] = 0;
      end
    end
  endtask

  // Called between edges: compare outputs, then advance the model across the next rising edge.
  task automatic do_cycle();
    for (int i = 0; i < 3; i++) begin
      int np = nports(i);
      int g = exp_grant(i);
      int key;
      logic [31:0] word;
      logic [2:0] er;
      er = (g >= 0) ? 3'(1 << g) : 3'b000;
      check_eq($sformatf("ready[inst%0d]", i), 32'(get_rdy(i)), 32'(er));
      for (int p = 0; p < np; p++) begin
        check_eq($sformatf("rsp_valid[inst%0d][%0d]", i, p), 32'(get_rv(i)[p]), 32'(m_rv[i][p]));
        if (m_known[i][p])
          check_eq($sformatf("rsp_rdata[inst%0d][%0d]", i, p), get_rd(i, p), m_rd[i][p]);
      end
      if (rst_n) begin
        for (int p = 0; p < np; p++) begin
          m_rv[i][p] = 1'b0;
          if (p == g) begin
            if (i != 1) check_eq($sformatf("rr_fair[inst%0d][%0d]", i, p), 32'(m_wait[i][p] < np), 32'd1);
            m_wait[i][p] = 0;
          end else if (s_vld[i][p]) begin
            m_wait[i][p]++;
          end
        end
        if (g >= 0) begin
          m_last[i] = g;
          s_acc[i][g] = 1'b1;
          key = i * 1024 + int'(s_addr[i][g]);
          word = m_mem.exists(key) ? m_mem[key] : 32'h0;
          if (s_wr[i][g]) begin
            for (int b = 0; b < 4; b++)
              if (s_be[i][g][b]) word[b*8 +: 8] = s_wd[i][g][b*8 +: 8];
            m_mem[key] = word;
          end else begin
            m_rv[i][g]    = 1'b1;
            m_rd[i][g]    = word;
            m_known[i][g] = m_mem.exists(key);
          end
        end
      end
    end
  endtask

  // mode 0 random (pct = valid probability), 1 fill via port 0, 2 directed byte-enable sequence on port 1, 3 idle
  task automatic gen_stim(int mode, int pct);
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < nports(i); p++) begin
        if (s_acc[i][p] || !s_vld[i][p]) begin
          s_acc[i][p] = 1'b0;
          s_vld[i][p] = 1'b0;
          case (mode)
            0: if ($urandom_range(99) < pct) begin
                 s_vld[i][p] = 1'b1; s_wr[i][p] = 1'($urandom_range(1));
                 s_addr[i][p] = 10'($urandom_range(15)); s_wd[i][p] = $urandom;
                 s_be[i][p] = 4'($urandom_range(15));
               end
            1: if (p == 0 && fill_cnt[i] < 16) begin
                 s_vld[i][p] = 1'b1; s_wr[i][p] = 1'b1; s_addr[i][p] = 10'(fill_cnt[i]);
                 s_wd[i][p] = $urandom; s_be[i][p] = 4'hF; fill_cnt[i]++;
               end
            2: if (p == 1 && dir_idx[i] < 3) begin
                 s_vld[i][p] = 1'b1; s_addr[i][p] = 10'd3;
                 s_wr[i][p] = (dir_idx[i] < 2);
                 s_wd[i][p] = (dir_idx[i] == 0) ? 32'hDEADBEEF : 32'h11223344;
                 s_be[i][p] = (dir_idx[i] == 0) ? 4'b1111 : 4'b0101;
                 dir_idx[i]++;
               end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic run(int n, int mode, int pct);
    repeat (n) begin
      @(negedge clk);
      do_cycle();
      @(posedge clk);
      #1;
      gen_stim(mode, pct);
    end
  endtask

  task automatic pulse_reset(int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      do_cycle();
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      fill_cnt[i] = 0; dir_idx[i] = 0;
      for (int p = 0; p < 3; p++) begin
        s_vld[i][p] = 1'b0; s_wr[i][p] = 1'b0; s_addr[i][p] = '0;
        s_wd[i][p] = '0; s_be[i][p] = '0; s_acc[i][p] = 1'b0;
      end
      s_vld[i][0] = 1'b1; s_addr[i][0] = 10'd5;
    end
    model_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      do_cycle();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(20, 1, 0);
    run(8, 2, 0);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("be_merge[inst%0d]", i), get_rd(i, 1), 32'hDE22BE44);
    run(400, 0, 60);
    run(300, 0, 100);
    pulse_reset(2);
    run(300, 0, 35);
    run(3, 3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
